// File: rtl/icarus_pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// occupancy states, per-boundary payload widths and the NOP encoding.
package icarus_pipe_pkg;

   // Occupancy of a stage register: nothing, MAIN only, MAIN plus SKID.
   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'd0,
      PIPE_BUSY  = 2'd1,
      PIPE_FULL  = 2'd2
   } pipe_state_e;

   // IF/ID carries the 32-bit instruction plus the 32-bit PC.
   localparam int unsigned IFID_WIDTH  = 64;
   // ID/EX carries PC, two operands, immediate and decoded control.
   localparam int unsigned IDEX_WIDTH  = 160;
   // EX/MEM carries ALU result, store data, destination and control.
   localparam int unsigned EXMEM_WIDTH = 80;
   // MEM/WB carries the write-back value, destination and write enable.
   localparam int unsigned MEMWB_WIDTH = 40;

   // All-zero instruction word decodes as a NOP.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Number of entries held in a given state.
   function automatic logic [1:0] occupancy_of(input pipe_state_e s);
      logic [1:0] n;
      case (s)
         PIPE_EMPTY: n = 2'd0;
         PIPE_BUSY:  n = 2'd1;
         PIPE_FULL:  n = 2'd2;
         default:    n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush to
// bubble, and an optional skid entry that makes In_Ready a register.
module pipe_stage_reg
   import icarus_pipe_pkg::*;
#(
   parameter int unsigned             DATA_WIDTH   = IFID_WIDTH,
   parameter logic [DATA_WIDTH-1:0]   BUBBLE_VALUE = {DATA_WIDTH{1'b0}},
   parameter bit                      SKID_EN      = 1'b1
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Flush,
   input  logic                  In_Valid,
   output logic                  In_Ready,
   input  logic [DATA_WIDTH-1:0] In_Data,
   output logic                  Out_Valid,
   input  logic                  Out_Ready,
   output logic [DATA_WIDTH-1:0] Out_Data,
   output logic [1:0]            Occupancy
);

   pipe_state_e           state_r;
   pipe_state_e           state_nxt_s;
   logic [DATA_WIDTH-1:0] main_r;
   logic [DATA_WIDTH-1:0] main_nxt_s;
   logic [DATA_WIDTH-1:0] skid_r;
   logic [DATA_WIDTH-1:0] skid_nxt_s;
   logic                  in_fire_s;
   logic                  out_fire_s;

   // Outputs are decoded straight from the state and MAIN registers.
   assign Out_Valid = (state_r != PIPE_EMPTY);
   assign Out_Data  = main_r;
   assign Occupancy = occupancy_of(state_r);

   // An input offered during a flush is dropped, never accepted.
   assign in_fire_s  = In_Valid & In_Ready & ~Flush;
   assign out_fire_s = Out_Valid & Out_Ready;

   // Next-state and storage update; flush overrides the normal transitions.
   always_comb begin
      state_nxt_s = state_r;
      main_nxt_s  = main_r;
      skid_nxt_s  = skid_r;
      if (Flush) begin
         state_nxt_s = PIPE_EMPTY;
         main_nxt_s  = BUBBLE_VALUE;
         skid_nxt_s  = {DATA_WIDTH{1'b0}};
      end else begin
         case (state_r)
            PIPE_EMPTY: begin
               if (in_fire_s) begin
                  state_nxt_s = PIPE_BUSY;
                  main_nxt_s  = In_Data;
               end else begin
                  state_nxt_s = PIPE_EMPTY;
               end
            end
            PIPE_BUSY: begin
               if (in_fire_s && out_fire_s) begin
                  state_nxt_s = PIPE_BUSY;
                  main_nxt_s  = In_Data;
               end else if (out_fire_s) begin
                  state_nxt_s = PIPE_EMPTY;
                  main_nxt_s  = BUBBLE_VALUE;
               end else if (in_fire_s && (SKID_EN == 1'b1)) begin
                  // Downstream stalled: absorb one more beat behind MAIN.
                  state_nxt_s = PIPE_FULL;
                  skid_nxt_s  = In_Data;
               end else begin
                  state_nxt_s = PIPE_BUSY;
               end
            end
            PIPE_FULL: begin
               // In_Ready is low here, so only a drain can happen.
               if (out_fire_s) begin
                  state_nxt_s = PIPE_BUSY;
                  main_nxt_s  = skid_r;
               end else begin
                  state_nxt_s = PIPE_FULL;
               end
            end
            default: begin
               state_nxt_s = PIPE_EMPTY;
               main_nxt_s  = BUBBLE_VALUE;
            end
         endcase
      end
   end

   // State and MAIN registers with synchronous reset to the bubble.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r <= PIPE_EMPTY;
         main_r  <= BUBBLE_VALUE;
      end else begin
         state_r <= state_nxt_s;
         main_r  <= main_nxt_s;
      end
   end

   generate
      if (SKID_EN) begin : g_skid
         logic in_ready_r;

         // SKID entry and registered In_Ready, low only when the stage will be full.
         always_ff @(posedge Clock) begin
            if (Reset) begin
               skid_r     <= {DATA_WIDTH{1'b0}};
               in_ready_r <= 1'b1;
            end else begin
               skid_r     <= skid_nxt_s;
               in_ready_r <= (state_nxt_s != PIPE_FULL);
            end
         end

         assign In_Ready = in_ready_r;
      end else begin : g_no_skid
         // Single-entry mode: accept whenever MAIN is free or draining now.
         assign skid_r   = {DATA_WIDTH{1'b0}};
         assign In_Ready = ~Out_Valid | Out_Ready;
      end
   endgenerate

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces fixed-width inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an arbitrary payload under a valid/ready handshake, supports flush-to-bubble, and optionally includes a skid entry so `In_Ready` is registered and stalls do not form a combinational path back up the pipeline. One instance sits between each pair of adjacent pipeline stages.

## Interface
- `DATA_WIDTH`, 64: payload width in bits. For IF/ID this is the instruction plus the PC.
- `BUBBLE_VALUE`, `{DATA_WIDTH{1'b0}}`: value driven on `Out_Data` after reset or flush. All zeros decodes as a NOP.
- `SKID_EN`, 1: 1 selects the 2-entry mode with registered `In_Ready`. 0 selects the 1-entry mode with combinational `In_Ready`.
- `Clock` in 1: the single clock. All state changes on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `Flush` in 1: squashes all held entries. Synchronous.
- `In_Valid` in 1: upstream offers `In_Data`.
- `In_Ready` out 1: the stage can accept data this cycle.
- `In_Data` in DATA_WIDTH: upstream payload.
- `Out_Valid` out 1: `Out_Data` is valid.
- `Out_Ready` in 1: downstream accepts this cycle.
- `Out_Data` out DATA_WIDTH: payload. Driven directly from the main register.
- `Occupancy` out 2: number of held entries, 0 to 2. It is always ≤1 when `SKID_EN`=0.

## Operation
- Transfer definitions:
  - in_fire = `In_Valid & In_Ready & !Flush`.
  - out_fire = `Out_Valid & Out_Ready`.
- Storage: a main register (MAIN), which drives `Out_Data`, and a skid register (SKID), which exists only when `SKID_EN`=1.
- States: EMPTY, BUSY (MAIN only), FULL (MAIN + SKID).
- Priority: Reset > Flush > normal transitions.
- Transitions:
  - EMPTY: in_fire → BUSY, with MAIN <= `In_Data`.
  - BUSY, in_fire and out_fire → BUSY, with MAIN <= `In_Data`.
  - BUSY, out_fire only → EMPTY, with MAIN <= `BUBBLE_VALUE`.
  - BUSY, in_fire only → FULL, with SKID <= `In_Data`. Only possible when `SKID_EN`=1.
  - FULL, out_fire → BUSY, with MAIN <= SKID.
  - FULL never sees in_fire, because `In_Ready`=0.
- `In_Ready`:
  - `SKID_EN`=1: registered; equals (next state != FULL).
  - `SKID_EN`=0: `!Out_Valid | Out_Ready`, combinational.
- Flush:
  - Next state is EMPTY; MAIN <= `BUBBLE_VALUE`; SKID is cleared; `In_Ready` <= 1.
  - An input offered in the flush cycle is dropped, not accepted.
  - An out_fire in the flush cycle still counts as delivered to downstream.
- Hold rule: while `Out_Valid` & !`Out_Ready`, `Out_Data` and `Out_Valid` must not change, except on Flush or Reset.
- Ordering: data leaves in acceptance order. The SKID entry always follows MAIN.
- Reset values: `Out_Valid`=0, `Out_Data`=`BUBBLE_VALUE`, `In_Ready`=1, `Occupancy`=0, state EMPTY.

## Timing
- Latency: in_fire at edge N gives `Out_Valid`=1 with that data after edge N, so it is visible in cycle N+1.
- Throughput: 1 transfer per cycle while `Out_Ready` is held at 1. A skid entry is never used in that case.
- Stall (`SKID_EN`=1): when `Out_Ready` drops, one more beat is absorbed into SKID. `In_Ready` falls the cycle after.
- Release: `Out_Ready` rising in FULL gives MAIN <= SKID, and `In_Ready` is 1 in the next cycle.
- Reset or Flush asserted mid-stall: both entries are discarded on that edge. `Out_Valid`=0 in the next cycle.
- Reset held over multiple cycles: outputs stay at their reset values. Inputs are ignored.

## Structure
- Shared package `icarus_pipe_pkg` holds:
  - the state enum (`PIPE_EMPTY`, `PIPE_BUSY`, `PIPE_FULL`);
  - `IFID_WIDTH`=64, `IDEX_WIDTH`, `EXMEM_WIDTH` and `MEMWB_WIDTH` constants;
  - `NOP_INSTR`=32'h0.
- No sub-module: MAIN, SKID and the state machine fit in a single module.
- The `SKID_EN`=0 path is a generate branch within the same module.

## Test plan
- Streaming: Reset for 2 cycles, then `In_Valid`=1 with data 1..8 on consecutive cycles and `Out_Ready`=1.
  - Required: `Out_Data` gives 1..8 in cycles 1..8 after the first accept; `In_Ready` stays 1; `Occupancy`≤1.
- Stall with `SKID_EN`=1: stream 0xA, 0xB, 0xC with `Out_Ready`=0 from the cycle 0xA appears.
  - Required: 0xB is absorbed into SKID; `In_Ready`=0; `Occupancy`=2; 0xC is held upstream.
  - Then `Out_Ready`=1 for 3 cycles. Required: 0xA, 0xB, 0xC are delivered in order with no gaps.
- Flush mid-stall: in FULL holding 0x11 and 0x22, assert `Flush` together with `In_Valid`=1 and data 0x33.
  - Required in the next cycle: `Out_Valid`=0, `Out_Data`=`BUBBLE_VALUE`, `Occupancy`=0, `In_Ready`=1.
  - 0x33 is never output.
- Reset priority: assert `Reset` and `Flush` together while BUSY with 0x5.
  - Required: reset values on every output; the next accepted value appears after exactly 1 cycle.
- `SKID_EN`=0: hold `Out_Ready`=0 with data 0x7 held.
  - Required: `In_Ready`=0 in the same cycle.
  - Raise `Out_Ready`. Required: `In_Ready`=1 combinationally; a simultaneous in_fire of 0x8 replaces 0x7 at the next edge.
- `DATA_WIDTH`=32, `BUBBLE_VALUE`=32'hDEADBEEF: after reset, `Out_Data`=32'hDEADBEEF and `Out_Valid`=0.
